// File: rtl/slot_alloc.sv
// slot_alloc: W-slot allocator with lowest-first or round-robin grant, legal/illegal free tracking.
// Optional sticky illegal-free flag enabled by defining SLOT_ALLOC_ERR_EN.
module slot_alloc #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alloc_vld,
  input  logic                 i_lowest,
  output logic                 o_alloc_rdy,
  output logic [$clog2(W)-1:0] o_alloc_id,
  input  logic                 i_free_vld,
  input  logic [$clog2(W)-1:0] i_free_id,
  output logic [W-1:0]         o_busy,
  output logic [$clog2(W):0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_err
);

  localparam int IW = $clog2(W);

  logic [W-1:0]  busy_q,  busy_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [IW:0]   count_q, count_d;
  logic [IW-1:0] lo_id_s, rr_id_s, idx_s;
  logic          grant_s, free_ok_s;

  // Free-slot search; loops run from the far end so the last hit is the first in scan order.
  always_comb begin
    lo_id_s = {IW{1'b0}};
    rr_id_s = {IW{1'b0}};
    idx_s   = {IW{1'b0}};
    for (int n = W - 1; n >= 0; n--) begin
      lo_id_s = busy_q[n] ? lo_id_s : IW'(n);
    end
    // k = W aliases to ptr itself, which is the last slot examined.
    for (int k = W; k >= 1; k--) begin
      idx_s   = ptr_q + IW'(k);
      rr_id_s = busy_q[idx_s] ? rr_id_s : idx_s;
    end
  end

  assign o_alloc_rdy = ~(&busy_q);
  assign o_alloc_id  = i_lowest ? lo_id_s : rr_id_s;
  assign o_full      = (count_q == (IW+1)'(W));
  assign o_empty     = (count_q == {(IW+1){1'b0}});
  assign grant_s     = i_alloc_vld & o_alloc_rdy;
  assign free_ok_s   = i_free_vld & busy_q[i_free_id];

  // Next-state for busy map, grant pointer and count.
  always_comb begin
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (free_ok_s) begin
      busy_d[i_free_id] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // A granted slot is free and a legal free targets a busy slot, so they never collide.
    if (grant_s) begin
      busy_d[o_alloc_id] = 1'b1;
      ptr_d              = o_alloc_id;
    end else begin
      ptr_d = ptr_q;
    end
    case ({grant_s, free_ok_s})
      2'b10:   count_d = count_q + (IW+1)'(1);
      2'b01:   count_d = count_q - (IW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= {W{1'b0}};
      ptr_q   <= {IW{1'b1}};
      count_q <= {(IW+1){1'b0}};
    end else begin
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_count = count_q;

`ifdef SLOT_ALLOC_ERR_EN
  logic err_q;

  // Sticky flag for a free of a slot that is not allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (i_free_vld & ~busy_q[i_free_id]) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_slot_alloc.sv
// Testbench for slot_alloc (W=8): directed vector table, hand sequences, and random
// stimulus checked against a behavioural model of the allocator rules.
module tb_slot_alloc;

  localparam int W = 8;
`ifdef SLOT_ALLOC_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, av, low, fv;
  logic [2:0] fid;
  logic       rdy, full, empty, err;
  logic [2:0] id;
  logic [7:0] busy;
  logic [3:0] cnt;

  slot_alloc #(.W(W)) dut (
    .clk(clk), .rst(rst), .i_alloc_vld(av), .i_lowest(low),
    .o_alloc_rdy(rdy), .o_alloc_id(id), .i_free_vld(fv), .i_free_id(fid),
    .o_busy(busy), .o_count(cnt), .o_full(full), .o_empty(empty), .o_err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit [7:0] m_busy;
  int       m_ptr;
  bit       m_err;
  bit       m_ok = 1'b0;
  int       m_exp;

  typedef struct {
    bit       r, a, l, f;
    bit [2:0] fid;
    bit       chk_pre;
    bit       rdy;
    int       id;
    bit [7:0] busy;
    int       cnt;
    bit       err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First free slot according to the rules; -1 if none.
  function automatic int model_id(input bit lowest);
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = lowest ? k : (m_ptr + 1 + k) % W;
      if (!m_busy[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive(input bit r, a, l, f, input bit [2:0] i);
    @(negedge clk);
    rst = r; av = a; low = l; fv = f; fid = i;
    #1;
    m_exp = -1;
    if (m_ok) begin
      m_exp = model_id(l);
      chk("m_rdy", rdy, (m_exp >= 0) ? 1 : 0);
      if (m_exp >= 0) chk("m_id", id, m_exp);
      chk("m_full", full, (m_busy == 8'hFF) ? 1 : 0);
      chk("m_empty", empty, (m_busy == 8'h00) ? 1 : 0);
    end
  endtask

  task automatic clock_and_check();
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 8'h00; m_ptr = W - 1; m_err = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (fv && !m_busy[fid]) m_err = 1'b1;
      if (fv && m_busy[fid]) m_busy[fid] = 1'b0;
      if (av && m_exp >= 0) begin
        m_busy[m_exp] = 1'b1;
        m_ptr = m_exp;
      end
    end
    if (m_ok) begin
      chk("m_busy", busy, m_busy);
      chk("m_count", cnt, $countones(m_busy));
      chk("m_err", err, m_err & ERR_ON);
    end
  endtask

  task automatic cyc(input bit r, a, l, f, input bit [2:0] i);
    drive(r, a, l, f, i);
    clock_and_check();
  endtask

  task automatic add(input bit r, a, l, f, input bit [2:0] i, input bit cp, rd,
                     input int xid, input bit [7:0] xb, input int xc, input bit xe);
    vec_t v;
    v.r = r; v.a = a; v.l = l; v.f = f; v.fid = i; v.chk_pre = cp; v.rdy = rd;
    v.id = xid; v.busy = xb; v.cnt = xc; v.err = xe;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; av = 1'b0; low = 1'b0; fv = 1'b0; fid = 3'd0;

    // Reset, then 8 round-robin grants 0..7, then full
    add(1, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 0, 3'd0, 1, 1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 1, 0, 0, 3'd0, 1, 1, k, 8'((16'd2 << k) - 16'd1), k + 1, 0);
    add(0, 1, 0, 0, 3'd0, 1, 0, 0, 8'hFF, 8, 0);
    // Full: free 3 with alloc held -> no bypass, grant 3 next cycle
    add(0, 1, 0, 1, 3'd3, 1, 0, 0, 8'hF7, 7, 0);
    add(0, 1, 0, 0, 3'd0, 1, 1, 3, 8'hFF, 8, 0);
    // Build busy=0000_0101, ptr=2
    add(1, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 3'd0, 1, 1, 0, 8'h01, 1, 0);
    add(0, 1, 1, 0, 3'd0, 1, 1, 1, 8'h03, 2, 0);
    add(0, 1, 1, 0, 3'd0, 1, 1, 2, 8'h07, 3, 0);
    add(0, 0, 0, 1, 3'd1, 1, 1, 3, 8'h05, 2, 0);
    add(0, 0, 0, 0, 3'd0, 1, 1, 3, 8'h05, 2, 0);
    add(0, 0, 1, 0, 3'd0, 1, 1, 1, 8'h05, 2, 0);
    // Illegal free while empty; error sticky, cleared by reset
    add(1, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 1, 3'd5, 1, 1, 0, 8'h00, 0, 1);
    add(0, 0, 0, 0, 3'd0, 1, 1, 0, 8'h00, 0, 1);
    add(1, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 0);
    // busy=01 then same-cycle grant and free of slot 0
    add(0, 1, 1, 0, 3'd0, 1, 1, 0, 8'h01, 1, 0);
    add(0, 1, 0, 1, 3'd0, 1, 1, 1, 8'h02, 1, 0);

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].a, tbl[n].l, tbl[n].f, tbl[n].fid);
      if (tbl[n].chk_pre) begin
        chk($sformatf("v%0d_rdy", n), rdy, tbl[n].rdy);
        if (tbl[n].rdy) chk($sformatf("v%0d_id", n), id, tbl[n].id);
      end
      clock_and_check();
      chk($sformatf("v%0d_busy", n), busy, tbl[n].busy);
      chk($sformatf("v%0d_count", n), cnt, tbl[n].cnt);
      chk($sformatf("v%0d_full", n), full, (tbl[n].cnt == 8) ? 1 : 0);
      chk($sformatf("v%0d_empty", n), empty, (tbl[n].cnt == 0) ? 1 : 0);
      chk($sformatf("v%0d_err", n), err, tbl[n].err & ERR_ON);
    end

    // busy=0111_1111, ptr=7: round-robin scan wraps through 0..6 to reach 7
    cyc(1, 0, 0, 0, 3'd0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0, 3'd0);
    cyc(0, 0, 0, 1, 3'd7);
    drive(0, 1, 0, 0, 3'd0);
    chk("wrap_id", id, 7);
    clock_and_check();
    chk("wrap_full", full, 1);

    // Reset mid-operation with pending alloc and free discards everything
    cyc(0, 0, 0, 1, 3'd2);
    drive(1, 1, 0, 1, 3'd4);
    clock_and_check();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", cnt, 0);
    drive(0, 0, 0, 0, 3'd0);
    chk("rst_mid_id", id, 0);
    chk("rst_mid_rdy", rdy, 1);
    clock_and_check();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 60),
          1'($urandom), ($urandom_range(0, 99) < 45), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slot_alloc.md
SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
REQ-001 SHALL have parameter W, default 8, number of allocatable slots; legal values are powers of two from 2 to 64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_alloc_vld  input  1  allocation request.
REQ-005 SHALL have port i_lowest  input  1  1 = grant lowest-index free slot; 0 = round-robin search.
REQ-006 SHALL have port o_alloc_rdy  output  1  a free slot exists; grant occurs when i_alloc_vld & o_alloc_rdy.
REQ-007 SHALL have port o_alloc_id  output  $clog2(W)  slot granted this cycle; valid when o_alloc_rdy=1.
REQ-008 SHALL have port i_free_vld  input  1  release request.
REQ-009 SHALL have port i_free_id  input  $clog2(W)  slot to release.
REQ-010 SHALL have port o_busy  output  W  registered busy bitmap, bit n = slot n allocated.
REQ-011 SHALL have port o_count  output  $clog2(W)+1  number of busy slots.
REQ-012 SHALL have ports o_full and o_empty  output  1 each  o_count==W and o_count==0 respectively.
REQ-013 SHALL have port o_err  output  1  sticky illegal-free flag (see Configuration).

Function
REQ-014 SHALL hold a W-bit busy register, a $clog2(W)-bit last-grant pointer ptr, and a count register.
REQ-015 o_alloc_rdy, o_alloc_id, o_full, o_empty SHALL be combinational from registered state only, never from i_free_*.
REQ-016 With i_lowest=1, o_alloc_id SHALL be the lowest index n with busy[n]=0.
REQ-017 With i_lowest=0, o_alloc_id SHALL be the first n with busy[n]=0 scanning ascending from (ptr+1) mod W, wrapping past W-1 to 0, ending at ptr.
REQ-018 On a grant, busy[o_alloc_id] SHALL be 1 and ptr SHALL equal o_alloc_id in the next cycle, in both modes.
REQ-019 When o_alloc_rdy=0, i_alloc_vld SHALL have no effect on any state.
REQ-020 On i_free_vld with busy[i_free_id]=1, busy[i_free_id] SHALL be 0 next cycle; ptr unchanged.
REQ-021 On i_free_vld with busy[i_free_id]=0 (illegal free), busy and count SHALL be unchanged.
REQ-022 A slot freed in cycle t SHALL become grantable no earlier than cycle t+1 (no same-cycle bypass).
REQ-023 Simultaneous legal grant and legal free SHALL both take effect; count unchanged.
REQ-024 Count SHALL update +1 per grant, -1 per legal free, with no wrap; equals popcount(busy) at all times.

Reset
REQ-025 While rst=1, busy SHALL clear to 0, count to 0, ptr to W-1, o_err to 0; alloc and free requests in that cycle SHALL be ignored.
REQ-026 After reset: o_alloc_rdy=1, o_alloc_id=0, o_empty=1, o_full=0, o_busy=0, o_count=0.
REQ-027 rst asserted mid-operation SHALL discard all allocations in the following cycle, regardless of pending requests.

Configuration
REQ-028 Macro SLOT_ALLOC_ERR_EN: when defined, o_err SHALL be a register set on any illegal free (REQ-021) and cleared only by rst.
REQ-029 When SLOT_ALLOC_ERR_EN is undefined, o_err SHALL be tied to 0 and no error register SHALL exist; REQ-021 behaviour is unchanged.

Verification (W=8)
REQ-030 Reset, then 8 back-to-back grants with i_lowest=0 -> ids 0,1,...,7; then o_full=1, o_alloc_rdy=0, o_count=8.
REQ-031 Full, free id 3 in cycle t with i_alloc_vld=1 held -> no grant in t; grant id 3 in t+1; o_count 7 then 8.
REQ-032 Busy=8'b0000_0101, ptr=2, i_lowest=0 -> o_alloc_id=3; same state with i_lowest=1 -> o_alloc_id=1.
REQ-033 Busy=8'b0111_1111, ptr=7, i_lowest=0 -> o_alloc_id=7 (wrap scan 0..6 all busy); after grant o_full=1.
REQ-034 Busy=8'b0000_0001, same-cycle grant and free id 0 -> next cycle busy=8'b0000_0010, o_count=1.
REQ-035 Free id 5 while empty -> busy, count unchanged; o_err=1 sticky with SLOT_ALLOC_ERR_EN, 0 without; rst clears it.
